// File: rtl/n1_mem_arbiter.sv
// n1_mem_arbiter: round-robin IF/LS/DBG arbiter for the single-port n1 RAM with one-cycle read response
module n1_mem_arbiter #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DEPTH  = 127,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_rdata,
  output logic              if_rsp_err,
  input  logic              ls_valid,
  output logic              ls_ready,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_rdata,
  output logic              ls_rsp_err,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_rsp_valid,
  output logic [DATA_W-1:0] dbg_rsp_rdata,
  output logic              dbg_rsp_err,
  input  logic              dbg_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {ID_IF = 2'd0, ID_LS = 2'd1, ID_DBG = 2'd2} id_t;
  localparam logic [ADDR_W:0] LIMIT = DEPTH[ADDR_W:0];
  id_t ptr, first, second, third, win, rsp_own;
  logic [2:0] cand;
  logic any, oor, win_we, rsp_v, rsp_err, rsp_rd;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata, rsp_data;
  function automatic id_t nxt(input id_t i);
    return i == ID_IF ? ID_LS : i == ID_LS ? ID_DBG : ID_IF;
  endfunction
  // pick the first valid candidate after the last winner; reset masks every request
  always_comb begin
    cand = rst_n ? {dbg_valid, ls_valid & ~dbg_lock, if_valid & ~dbg_lock} : 3'b000;
    first = nxt(ptr);
    second = nxt(first);
    third = nxt(second);
    any = |cand;
    win = cand[first] ? first : cand[second] ? second : third;
    win_we = win == ID_LS ? ls_we : win == ID_DBG ? dbg_we : 1'b0;
    win_addr = win == ID_LS ? ls_addr : win == ID_DBG ? dbg_addr : if_addr;
    win_wdata = win == ID_LS ? ls_wdata : win == ID_DBG ? dbg_wdata : '0;
    oor = {1'b0, win_addr} >= LIMIT;
  end
  assign if_ready  = any && win == ID_IF;
  assign ls_ready  = any && win == ID_LS;
  assign dbg_ready = any && win == ID_DBG;
  assign mem_en    = any && !oor;
  assign mem_we    = mem_en && win_we;
  assign mem_addr  = any ? win_addr : '0;
  assign mem_wdata = any ? win_wdata : '0;
  // pointer remembers the last winner; response stage records who gets next cycle's pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= ID_DBG;
      rsp_v <= 1'b0;
      rsp_own <= ID_IF;
      rsp_err <= 1'b0;
      rsp_rd <= 1'b0;
    end else begin
      if (any) ptr <= win;
      rsp_v <= any;
      rsp_own <= win;
      rsp_err <= any && oor;
      rsp_rd <= any && !oor && !win_we;
    end
  end
  // steer the registered response to its owner; only in-range reads carry RAM data
  always_comb begin
    rsp_data = rsp_rd ? mem_rdata : '0;
    if_rsp_valid = rsp_v && rsp_own == ID_IF;
    ls_rsp_valid = rsp_v && rsp_own == ID_LS;
    dbg_rsp_valid = rsp_v && rsp_own == ID_DBG;
    if_rsp_err = rsp_err && rsp_own == ID_IF;
    ls_rsp_err = rsp_err && rsp_own == ID_LS;
    dbg_rsp_err = rsp_err && rsp_own == ID_DBG;
    if_rsp_rdata = rsp_own == ID_IF ? rsp_data : '0;
    ls_rsp_rdata = rsp_own == ID_LS ? rsp_data : '0;
    dbg_rsp_rdata = rsp_own == ID_DBG ? rsp_data : '0;
  end
endmodule

// File: tb/tb_n1_mem_arbiter.sv
// tb_n1_mem_arbiter: table-driven grant checks with a response scoreboard and behavioural RAM
module tb_n1_mem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_valid, if_ready, if_rsp_valid, if_rsp_err;
  logic ls_valid, ls_ready, ls_we, ls_rsp_valid, ls_rsp_err;
  logic dbg_valid, dbg_ready, dbg_we, dbg_rsp_valid, dbg_rsp_err, dbg_lock;
  logic mem_en, mem_we;
  logic [6:0] if_addr, ls_addr, dbg_addr, mem_addr;
  logic [15:0] ls_wdata, dbg_wdata, mem_wdata, mem_rdata = 16'h0;
  logic [15:0] if_rsp_rdata, ls_rsp_rdata, dbg_rsp_rdata;
  typedef struct packed {
    logic [2:0] v; logic lock, ls_we, dbg_we;
    logic [6:0] a_if, a_ls, a_dbg;
    logic [15:0] d_ls, d_dbg;
    logic [2:0] gnt;
  } vec_t;
  typedef struct packed { logic [2:0] v; logic [15:0] rd; logic err; } rsp_t;
  rsp_t q[$];
  vec_t tbl[27];
  logic [15:0] ram[0:127];
  logic [15:0] shadow[0:127];
  logic loaded = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  n1_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata), .if_rsp_err(if_rsp_err),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata), .ls_rsp_err(ls_rsp_err),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_err(dbg_rsp_err),
    .dbg_lock(dbg_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 16'h0101) ^ 16'h3c5a;
  endfunction
  // behavioural single-port RAM with one-cycle read latency
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 128; i++) ram[i] <= init_val(i);
      loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_ctrl"}, 64'({if_ready, ls_ready, dbg_ready, if_rsp_valid, ls_rsp_valid, dbg_rsp_valid,
        if_rsp_err, ls_rsp_err, dbg_rsp_err, mem_en, mem_we, mem_addr, mem_wdata}), 64'h0);
    chk({name, "_rdata"}, 64'({if_rsp_rdata, ls_rsp_rdata, dbg_rsp_rdata}), 64'h0);
  endtask
  function automatic vec_t mk(input logic [2:0] v, input logic lock, lw, dw,
                              input logic [6:0] ai, al, ad, input logic [15:0] dl, dd, input logic [2:0] g);
    return '{v: v, lock: lock, ls_we: lw, dbg_we: dw, a_if: ai, a_ls: al, a_dbg: ad, d_ls: dl, d_dbg: dd, gnt: g};
  endfunction
  task automatic step(input vec_t t);
    rsp_t e;
    logic [6:0] a;
    logic we;
    logic [15:0] d;
    if_valid = t.v[0]; ls_valid = t.v[1]; dbg_valid = t.v[2]; dbg_lock = t.lock;
    ls_we = t.ls_we; dbg_we = t.dbg_we;
    if_addr = t.a_if; ls_addr = t.a_ls; dbg_addr = t.a_dbg;
    ls_wdata = t.d_ls; dbg_wdata = t.d_dbg;
    #1;
    e = '0;
    if (q.size() > 0) e = q.pop_front();
    chk("rsp_valid", 64'({dbg_rsp_valid, ls_rsp_valid, if_rsp_valid}), 64'(e.v));
    chk("rsp_err", 64'({dbg_rsp_err, ls_rsp_err, if_rsp_err}), 64'(e.err ? e.v : 3'b000));
    chk("rsp_rdata", 64'({dbg_rsp_rdata, ls_rsp_rdata, if_rsp_rdata}),
        64'({e.v[2] ? e.rd : 16'h0, e.v[1] ? e.rd : 16'h0, e.v[0] ? e.rd : 16'h0}));
    chk("ready", 64'({dbg_ready, ls_ready, if_ready}), 64'(t.gnt));
    a = t.gnt[2] ? t.a_dbg : t.gnt[1] ? t.a_ls : t.a_if;
    we = t.gnt[2] ? t.dbg_we : t.gnt[1] ? t.ls_we : 1'b0;
    d = t.gnt[2] ? t.d_dbg : t.gnt[1] ? t.d_ls : 16'h0;
    if (t.gnt == 3'b000) chk("mem_idle", 64'(mem_en), 64'h0);
    else if (a < 7'd127) begin
      chk("mem_drive", 64'({mem_en, mem_we, mem_addr, we ? mem_wdata : 16'h0}), 64'({1'b1, we, a, we ? d : 16'h0}));
      q.push_back('{v: t.gnt, rd: we ? 16'h0 : shadow[a], err: 1'b0});
      if (we) shadow[a] = d;
    end else begin
      chk("mem_oor", 64'({mem_en, mem_we}), 64'h0);
      q.push_back('{v: t.gnt, rd: 16'h0, err: 1'b1});
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    int diffs;
    for (int i = 0; i < 128; i++) shadow[i] = init_val(i);
    tbl[0]  = mk(3'b111, 0, 0, 0, 7'd10, 7'd20, 7'd30, 16'h0, 16'h0, 3'b001);
    tbl[1]  = mk(3'b111, 0, 0, 0, 7'd11, 7'd20, 7'd30, 16'h0, 16'h0, 3'b010);
    tbl[2]  = mk(3'b111, 0, 0, 0, 7'd11, 7'd21, 7'd30, 16'h0, 16'h0, 3'b100);
    tbl[3]  = mk(3'b111, 0, 0, 0, 7'd11, 7'd21, 7'd31, 16'h0, 16'h0, 3'b001);
    tbl[4]  = mk(3'b111, 0, 0, 0, 7'd12, 7'd21, 7'd31, 16'h0, 16'h0, 3'b010);
    tbl[5]  = mk(3'b111, 0, 0, 0, 7'd12, 7'd22, 7'd31, 16'h0, 16'h0, 3'b100);
    tbl[6]  = mk(3'b010, 0, 1, 0, 7'd0, 7'd5, 7'd0, 16'hBEEF, 16'h0, 3'b010);
    tbl[7]  = mk(3'b001, 0, 0, 0, 7'd5, 7'd0, 7'd0, 16'h0, 16'h0, 3'b001);
    tbl[8]  = mk(3'b100, 0, 0, 1, 7'd0, 7'd0, 7'd127, 16'h0, 16'h1234, 3'b100);
    tbl[9]  = mk(3'b100, 0, 0, 0, 7'd0, 7'd0, 7'd127, 16'h0, 16'h0, 3'b100);
    tbl[10] = mk(3'b101, 0, 0, 0, 7'd50, 7'd0, 7'd60, 16'h0, 16'h0, 3'b001);
    tbl[11] = mk(3'b101, 1, 0, 0, 7'd51, 7'd0, 7'd60, 16'h0, 16'h0, 3'b100);
    tbl[12] = mk(3'b101, 1, 0, 1, 7'd51, 7'd0, 7'd61, 16'h0, 16'h7777, 3'b100);
    tbl[13] = mk(3'b001, 1, 0, 0, 7'd51, 7'd0, 7'd0, 16'h0, 16'h0, 3'b000);
    tbl[14] = mk(3'b001, 0, 0, 0, 7'd51, 7'd0, 7'd0, 16'h0, 16'h0, 3'b001);
    tbl[15] = mk(3'b010, 0, 0, 0, 7'd0, 7'd70, 7'd0, 16'h0, 16'h0, 3'b010);
    tbl[16] = mk(3'b000, 0, 0, 0, 7'd0, 7'd0, 7'd0, 16'h0, 16'h0, 3'b000);
    tbl[17] = tbl[16];
    tbl[18] = tbl[16];
    tbl[19] = mk(3'b111, 0, 0, 0, 7'd126, 7'd71, 7'd61, 16'h0, 16'h0, 3'b100);
    tbl[20] = mk(3'b111, 0, 0, 0, 7'd126, 7'd71, 7'd62, 16'h0, 16'h0, 3'b001);
    tbl[21] = mk(3'b111, 0, 0, 0, 7'd0, 7'd71, 7'd62, 16'h0, 16'h0, 3'b010);
    tbl[22] = mk(3'b111, 0, 1, 0, 7'd0, 7'd40, 7'd62, 16'hA5A5, 16'h0, 3'b100);
    tbl[23] = mk(3'b011, 0, 1, 0, 7'd0, 7'd40, 7'd0, 16'hA5A5, 16'h0, 3'b001);
    tbl[24] = mk(3'b011, 0, 1, 0, 7'd40, 7'd40, 7'd0, 16'hA5A5, 16'h0, 3'b010);
    tbl[25] = mk(3'b001, 0, 0, 0, 7'd40, 7'd0, 7'd0, 16'h0, 16'h0, 3'b001);
    tbl[26] = tbl[16];
    if_valid = 1'b1; ls_valid = 1'b1; dbg_valid = 1'b1; dbg_lock = 1'b0;
    ls_we = 1'b1; dbg_we = 1'b1; if_addr = 7'd3; ls_addr = 7'd4; dbg_addr = 7'd5;
    ls_wdata = 16'h1111; dbg_wdata = 16'h2222;
    #1;
    chk_zero("reset_init");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 27; i++) step(tbl[i]);
    step(mk(3'b010, 0, 0, 0, 7'd0, 7'd7, 7'd0, 16'h0, 16'h0, 3'b010));
    if_valid = 1'b1; ls_valid = 1'b1; dbg_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("reset_mid");
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(mk(3'b111, 0, 0, 0, 7'd20, 7'd30, 7'd40, 16'h0, 16'h0, 3'b001));
    step(tbl[16]);
    diffs = 0;
    for (int i = 0; i < 127; i++) if (ram[i] !== shadow[i]) diffs++;
    chk("ram_intact", 64'(diffs), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
